bits_group_sum: RTL and testbench



---
 rtl/bits_group_sum.sv | 166 ++++++++++++++++
 tb/tb_bits_group_sum.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bits_group_sum.sv
// bits_group_sum: buffers a stream of unsigned samples in a small FIFO, sums them in fixed
// groups of GROUP samples and presents each saturated sum on a valid/ready output port.
module bits_group_sum #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned GROUP = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OBITS = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NBITS-1:0]         i_din,
  input  logic                     i_din_valid,
  output logic                     o_din_ready,
  output logic [OBITS-1:0]         o_dout,
  output logic                     o_dout_valid,
  input  logic                     i_dout_ready,
  output logic                     o_ovf,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (GROUP > 2) ? $clog2(GROUP) : 1;
  localparam int unsigned SW = OBITS + 1;

  localparam logic [SW-1:0]    SatMax = {1'b0, {OBITS{1'b1}}};
  localparam logic [CW-1:0]    CntLast = CW'(GROUP - 1);
  localparam logic [LW-1:0]    LevelFull = LW'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  // FIFO storage and pointers
  logic [NBITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_din_ready;

  // Group accumulator and result registers
  logic [1:0]       r_state;
  logic [OBITS-1:0] r_acc;
  logic             r_sticky;
  logic [CW-1:0]    r_cnt;
  logic [OBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_ovf;

  logic             w_push;
  logic             w_pop;
  logic [NBITS-1:0] w_sample;
  logic [LW-1:0]    w_level_next;
  logic [OBITS-1:0] w_acc_base;
  logic [SW-1:0]    w_sum;
  logic             w_clamp;
  logic [OBITS-1:0] w_sat;

  logic [1:0]       w_state_next;
  logic [OBITS-1:0] w_acc_next;
  logic             w_sticky_next;
  logic [CW-1:0]    w_cnt_next;
  logic [OBITS-1:0] w_dout_next;
  logic             w_dout_valid_next;
  logic             w_ovf_next;

  // Handshake decode: ready is registered from the level, so a full FIFO refuses even
  // when a pop happens on the same edge.
  always_comb begin
    w_push   = i_din_valid && r_din_ready;
    w_pop    = (r_level != '0) && (!r_dout_valid || i_dout_ready);
    w_sample = r_mem[r_rd_ptr];
    w_level_next = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Widened sum and its saturated form
  always_comb begin
    w_acc_base = (r_state == StAccum) ? r_acc : '0;
    w_sum      = SW'(w_acc_base) + SW'(w_sample);
    w_clamp    = (w_sum > SatMax);
    w_sat      = w_clamp ? {OBITS{1'b1}} : w_sum[OBITS-1:0];
  end

  // Group FSM next state: a transfer and a pop may share an edge, so the pop starts the
  // next group without a bubble.
  always_comb begin
    w_state_next      = r_state;
    w_acc_next        = r_acc;
    w_sticky_next     = r_sticky;
    w_cnt_next        = r_cnt;
    w_dout_next       = r_dout;
    w_dout_valid_next = r_dout_valid;
    w_ovf_next        = r_ovf;

    if (r_dout_valid && i_dout_ready) begin
      w_dout_valid_next = 1'b0;
      w_ovf_next        = 1'b0;
      w_state_next      = StIdle;
    end

    if (w_pop) begin
      if (r_cnt == CntLast) begin
        w_dout_next       = w_sat;
        w_ovf_next        = w_clamp | r_sticky;
        w_dout_valid_next = 1'b1;
        w_acc_next        = '0;
        w_sticky_next     = 1'b0;
        w_cnt_next        = '0;
        w_state_next      = StHold;
      end else begin
        w_acc_next    = w_sat;
        w_sticky_next = (r_state == StAccum) ? (r_sticky | w_clamp) : w_clamp;
        w_cnt_next    = r_cnt + CW'(1);
        w_state_next  = StAccum;
      end
    end
  end

  // FIFO storage write; contents need no reset because the pointers define validity
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_din_ready  <= 1'b0;
      r_state      <= StIdle;
      r_acc        <= '0;
      r_sticky     <= 1'b0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level      <= w_level_next;
      r_din_ready  <= (w_level_next != LevelFull);
      r_state      <= w_state_next;
      r_acc        <= w_acc_next;
      r_sticky     <= w_sticky_next;
      r_cnt        <= w_cnt_next;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_dout_valid_next;
      r_ovf        <= w_ovf_next;
    end
  end

  assign o_din_ready  = r_din_ready;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_ovf        = r_ovf;
  assign o_level      = r_level;

endmodule

// File: tb/tb_bits_group_sum.sv
// tb_bits_group_sum: directed bench driving two instances (OBITS=6 and OBITS=5) with the
// same stimulus; table of groups plus hand-written multi-cycle sequences.
module tb_bits_group_sum;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       dout_ready;

  logic       rdy6, vld6, ovf6;
  logic [5:0] dout6;
  logic [2:0] lvl6;
  logic       rdy5, vld5, ovf5;
  logic [4:0] dout5;
  logic [2:0] lvl5;

  int checks = 0;
  int errors = 0;

  bits_group_sum #(.NBITS(4), .GROUP(4), .DEPTH(4), .OBITS(6)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_din_valid(din_valid),
    .o_din_ready(rdy6), .o_dout(dout6), .o_dout_valid(vld6), .i_dout_ready(dout_ready),
    .o_ovf(ovf6), .o_level(lvl6)
  );

  bits_group_sum #(.NBITS(4), .GROUP(4), .DEPTH(4), .OBITS(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_din_valid(din_valid),
    .o_din_ready(rdy5), .o_dout(dout5), .o_dout_valid(vld5), .i_dout_ready(dout_ready),
    .o_ovf(ovf5), .o_level(lvl5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] samples;  // sample i in bits [4*i +: 4]
    int          exp6;
    int          exp5;
    logic        eovf6;
    logic        eovf5;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    rst_n      = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Push four samples back to back with the sink ready; the result must be valid only
  // right after the edge that pops the fourth sample (first push edge + 4).
  task automatic apply_group(input string name, input vec_t v);
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din       = v.samples[4*i +: 4];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    chk({name, " early_valid"}, {31'd0, vld6}, 32'd0);
    step();
    chk({name, " valid6"}, {31'd0, vld6}, 32'd1);
    chk({name, " valid5"}, {31'd0, vld5}, 32'd1);
    chk({name, " dout6"}, {26'd0, dout6}, v.exp6);
    chk({name, " dout5"}, {27'd0, dout5}, v.exp5);
    chk({name, " ovf6"}, {31'd0, ovf6}, {31'd0, v.eovf6});
    chk({name, " ovf5"}, {31'd0, ovf5}, {31'd0, v.eovf5});
    step();
    chk({name, " valid_drop"}, {31'd0, vld6}, 32'd0);
    chk({name, " ovf_drop"}, {31'd0, ovf5}, 32'd0);
  endtask

  // Fill under backpressure: 2s offered for 12 cycles with the sink stalled
  task automatic fill_backpressure(input string name, input bit check_hold);
    dout_ready = 1'b0;
    din        = 4'd2;
    din_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (check_hold && i >= 4) begin
        chk({name, " hold_valid"}, {31'd0, vld6}, 32'd1);
        chk({name, " hold_dout"}, {26'd0, dout6}, 32'd8);
      end
    end
    din_valid = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{samples: {4'd3, 4'd3, 4'd3, 4'd3},     exp6: 12, exp5: 12, eovf6: 0, eovf5: 0};
    vecs[1] = '{samples: {4'd15, 4'd15, 4'd15, 4'd15}, exp6: 60, exp5: 31, eovf6: 0, eovf5: 1};
    vecs[2] = '{samples: {4'd1, 4'd1, 4'd1, 4'd1},     exp6: 4,  exp5: 4,  eovf6: 0, eovf5: 0};
    vecs[3] = '{samples: {4'd7, 4'd8, 4'd8, 4'd8},     exp6: 31, exp5: 31, eovf6: 0, eovf5: 0};
    vecs[4] = '{samples: {4'd8, 4'd8, 4'd8, 4'd8},     exp6: 32, exp5: 31, eovf6: 0, eovf5: 1};
    vecs[5] = '{samples: {4'd0, 4'd15, 4'd15, 4'd15},  exp6: 45, exp5: 31, eovf6: 0, eovf5: 1};
    vecs[6] = '{samples: {4'd0, 4'd0, 4'd0, 4'd0},     exp6: 0,  exp5: 0,  eovf6: 0, eovf5: 0};

    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    rst_n      = 1'b0;

    // Reset state
    step();
    chk("rst dout6", {26'd0, dout6}, 32'd0);
    chk("rst valid6", {31'd0, vld6}, 32'd0);
    chk("rst ovf6", {31'd0, ovf6}, 32'd0);
    chk("rst level6", {29'd0, lvl6}, 32'd0);
    chk("rst ready6", {31'd0, rdy6}, 32'd0);
    chk("rst ready5", {31'd0, rdy5}, 32'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", {31'd0, rdy6}, 32'd0);
    step();
    chk("ready_after_release", {31'd0, rdy6}, 32'd1);

    // Table of single groups (basic, saturation boundaries, sticky overflow)
    foreach (vecs[i]) apply_group($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back groups: 1..8 streamed, results after edges k+4 and k+8
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        din       = 4'(i + 1);
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      step();
      if (i < 8) chk($sformatf("b2b ready%0d", i), {31'd0, rdy6}, 32'd1);
      chk($sformatf("b2b valid%0d", i), {31'd0, vld6}, {31'd0, (i == 4 || i == 8)});
      if (i == 4) chk("b2b dout_a", {26'd0, dout6}, 32'd10);
      if (i == 8) begin
        chk("b2b dout_b6", {26'd0, dout6}, 32'd26);
        chk("b2b dout_b5", {27'd0, dout5}, 32'd26);
      end
    end

    // Backpressure: held result, FIFO fills, then drains in order
    do_reset();
    fill_backpressure("bp", 1'b1);
    chk("bp level_full", {29'd0, lvl6}, 32'd4);
    chk("bp ready_low", {31'd0, rdy6}, 32'd0);
    chk("bp dout_held", {26'd0, dout6}, 32'd8);
    begin
      int xfers;
      xfers = 0;
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (vld6 && dout_ready) begin
          xfers++;
          chk($sformatf("bp xfer%0d", xfers), {26'd0, dout6}, 32'd8);
        end
        step();
      end
      chk("bp xfer_count", xfers, 32'd2);
      chk("bp level_drained", {29'd0, lvl6}, 32'd0);
      chk("bp ready_back", {31'd0, rdy6}, 32'd1);
    end

    // Reset mid-group: partial 5+5 discarded
    do_reset();
    din       = 4'd5;
    din_valid = 1'b1;
    step();
    step();
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("midrst dout6", {26'd0, dout6}, 32'd0);
    chk("midrst dout5", {27'd0, dout5}, 32'd0);
    chk("midrst valid", {31'd0, vld6}, 32'd0);
    chk("midrst ovf", {31'd0, ovf5}, 32'd0);
    chk("midrst level", {29'd0, lvl6}, 32'd0);
    chk("midrst ready", {31'd0, rdy6}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    apply_group("midrst_after", vecs[2]);

    // Simultaneous push/pop at full: pop happens, push refused, next push accepted
    do_reset();
    fill_backpressure("full", 1'b0);
    chk("full level", {29'd0, lvl6}, 32'd4);
    dout_ready = 1'b1;
    din        = 4'd7;
    din_valid  = 1'b1;
    step();
    chk("full pop_level", {29'd0, lvl6}, 32'd3);
    chk("full xfer_valid", {31'd0, vld6}, 32'd0);
    chk("full ready_again", {31'd0, rdy6}, 32'd1);
    step();
    din_valid = 1'b0;
    chk("full push_accepted_level", {29'd0, lvl6}, 32'd3);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (vld6) begin
          seen++;
          chk("full group_after", {26'd0, dout6}, 32'd8);
        end
      end
      chk("full group_count", seen, 32'd1);
      chk("full level_tail", {29'd0, lvl6}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
